// File: rtl/vend_transaction_fsm.sv
// vend_transaction_fsm
//   Customer-transaction stage that sits in front of the dispensing controller.
//   It collects coin credit and takes an item selection, then reads the item price.
//   When credit covers the price it issues a one-cycle dispense command and tracks
//   the controller's active/error response. At the end it pays out change or a full refund.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   coin_valid_i/value  coin strobe and value in cents
//   sel_valid_i/item    item selection strobe and index
//   cancel_i            refund request strobe
//   price_addr_o/data_i price table read port (data valid one cycle after address)
//   dispense_cmd_o      one-cycle dispense request; item_select_o is the item
//   dispense_active_i   controller busy; error_state_i controller fault
//   credit_o            current credit
//   coin_reject_o, insufficient_o, fault_o   one-cycle status pulses
//   change_valid_o/change_amount_o           one-cycle payout
//   busy_o              high whenever the FSM is not idle
module vend_transaction_fsm #(
    parameter int unsigned NUM_ITEMS    = 16,
    parameter int unsigned CREDIT_W     = 12,
    parameter int unsigned MAX_CREDIT   = 1000,
    parameter int unsigned ACK_TIMEOUT  = 16,
    parameter int unsigned IDLE_TIMEOUT = 500000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid_i,
    input  logic [7:0]          coin_value_i,
    input  logic                sel_valid_i,
    input  logic [3:0]          sel_item_i,
    input  logic                cancel_i,
    output logic [3:0]          price_addr_o,
    input  logic [7:0]          price_data_i,
    output logic                dispense_cmd_o,
    output logic [3:0]          item_select_o,
    input  logic                dispense_active_i,
    input  logic                error_state_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                coin_reject_o,
    output logic                insufficient_o,
    output logic                fault_o,
    output logic                change_valid_o,
    output logic [CREDIT_W-1:0] change_amount_o,
    output logic                busy_o
);

    localparam int unsigned AckW  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StPrice, StCheck, StIssue, StWaitAck, StWaitDone, StPayout
    } state_e;

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] price_q;
    logic [3:0]          item_q;
    logic [AckW-1:0]     ack_cnt_q;
    logic [IdleW-1:0]    idle_cnt_q;
    logic                active_q;

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] credit_upd;
    logic [CREDIT_W-1:0] price_ext;
    logic                sel_ok;
    logic                strobe;

    // Extra MSB on the sum so the MAX_CREDIT compare can never see a wrapped value.
    always_comb begin
        coin_sum   = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value_i);
        coin_ok    = coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT);
        credit_upd = (coin_valid_i && coin_ok) ? coin_sum[CREDIT_W-1:0] : credit_q;
        price_ext  = CREDIT_W'(price_data_i);
        sel_ok     = sel_valid_i && (32'(sel_item_i) < NUM_ITEMS);
        strobe     = coin_valid_i || sel_valid_i || cancel_i;
    end

    assign credit_o      = credit_q;
    assign price_addr_o  = item_q;
    assign item_select_o = item_q;
    assign busy_o        = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            credit_q        <= '0;
            price_q         <= '0;
            item_q          <= '0;
            ack_cnt_q       <= '0;
            idle_cnt_q      <= '0;
            active_q        <= 1'b0;
            dispense_cmd_o  <= 1'b0;
            coin_reject_o   <= 1'b0;
            insufficient_o  <= 1'b0;
            fault_o         <= 1'b0;
            change_valid_o  <= 1'b0;
            change_amount_o <= '0;
        end else begin
            dispense_cmd_o  <= 1'b0;
            coin_reject_o   <= 1'b0;
            insufficient_o  <= 1'b0;
            fault_o         <= 1'b0;
            change_valid_o  <= 1'b0;
            change_amount_o <= '0;
            active_q        <= dispense_active_i;

            // Coins are only banked in IDLE; anywhere else they go straight back.
            if (coin_valid_i && (state_q != StIdle || !coin_ok)) begin
                coin_reject_o <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    credit_q <= credit_upd;
                    // A coin accepted in the same cycle as cancel is refunded too.
                    if (cancel_i && credit_upd != '0) begin
                        change_valid_o  <= 1'b1;
                        change_amount_o <= credit_upd;
                        idle_cnt_q      <= '0;
                        state_q         <= StPayout;
                    end else if (sel_ok) begin
                        item_q     <= sel_item_i;
                        idle_cnt_q <= '0;
                        state_q    <= StPrice;
                    end else if (strobe || credit_q == '0) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IdleW'(IDLE_TIMEOUT - 1)) begin
                        change_valid_o  <= 1'b1;
                        change_amount_o <= credit_q;
                        idle_cnt_q      <= '0;
                        state_q         <= StPayout;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                StPrice: state_q <= StCheck;
                StCheck: begin
                    price_q <= price_ext;
                    // A zero price marks a disabled item.
                    if (price_data_i == 8'd0 || credit_q < price_ext) begin
                        insufficient_o <= 1'b1;
                        state_q        <= StIdle;
                    end else begin
                        dispense_cmd_o <= 1'b1;
                        ack_cnt_q      <= '0;
                        state_q        <= StIssue;
                    end
                end
                StIssue: state_q <= StWaitAck;
                StWaitAck: begin
                    if (error_state_i || ack_cnt_q == AckW'(ACK_TIMEOUT - 1)) begin
                        // Errors take priority over a same-cycle active.
                        if (error_state_i || !dispense_active_i) begin
                            fault_o         <= 1'b1;
                            change_valid_o  <= (credit_q != '0);
                            change_amount_o <= credit_q;
                            state_q         <= StPayout;
                        end else begin
                            state_q <= StWaitDone;
                        end
                    end else if (dispense_active_i) begin
                        state_q <= StWaitDone;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    // CHECK already guaranteed credit >= price, so this cannot underflow.
                    if (active_q && !dispense_active_i) begin
                        credit_q        <= credit_q - price_q;
                        change_valid_o  <= (credit_q != price_q);
                        change_amount_o <= credit_q - price_q;
                        state_q         <= StPayout;
                    end
                end
                StPayout: begin
                    credit_q <= '0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_transaction_fsm.sv
module tb_vend_transaction_fsm;

    logic        clk;
    logic        rst_n;
    logic        coin_valid;
    logic [7:0]  coin_value;
    logic        sel_valid;
    logic [3:0]  sel_item;
    logic        cancel;
    logic [3:0]  price_addr;
    logic [7:0]  price_data;
    logic        dispense_cmd;
    logic [3:0]  item_select;
    logic        dispense_active;
    logic        error_state;
    logic [11:0] credit;
    logic        coin_reject;
    logic        insufficient;
    logic        fault;
    logic        change_valid;
    logic [11:0] change_amount;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] prices [16];

    vend_transaction_fsm #(
        .IDLE_TIMEOUT(40)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .coin_valid_i     (coin_valid),
        .coin_value_i     (coin_value),
        .sel_valid_i      (sel_valid),
        .sel_item_i       (sel_item),
        .cancel_i         (cancel),
        .price_addr_o     (price_addr),
        .price_data_i     (price_data),
        .dispense_cmd_o   (dispense_cmd),
        .item_select_o    (item_select),
        .dispense_active_i(dispense_active),
        .error_state_i    (error_state),
        .credit_o         (credit),
        .coin_reject_o    (coin_reject),
        .insufficient_o   (insufficient),
        .fault_o          (fault),
        .change_valid_o   (change_valid),
        .change_amount_o  (change_amount),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered price table: data follows the address by one clock.
    always @(posedge clk) price_data <= prices[price_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [7:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
        coin_value = 8'd0;
    endtask

    task automatic select(input logic [3:0] i);
        sel_valid = 1'b1;
        sel_item  = i;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    initial begin
        foreach (prices[i]) prices[i] = 8'd50;
        prices[2] = 8'd60;
        prices[3] = 8'd75;
        prices[5] = 8'd25;
        prices[7] = 8'd0;
        price_data      = 8'd0;
        rst_n           = 1'b0;
        coin_valid      = 1'b0;
        coin_value      = 8'd0;
        sel_valid       = 1'b0;
        sel_item        = 4'd0;
        cancel          = 1'b0;
        dispense_active = 1'b0;
        error_state     = 1'b0;
        repeat (3) step();
        check_eq("rst_credit", 32'(credit), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_change_valid", 32'(change_valid), 0);
        rst_n = 1'b1;
        step();

        // 1: 25+25+50, item 3 @75, 10 active cycles, change 25
        put_coin(8'd25);
        put_coin(8'd25);
        put_coin(8'd50);
        check_eq("t1_credit", 32'(credit), 100);
        select(4'd3);
        check_eq("t1_busy", 32'(busy), 1);
        check_eq("t1_cmd_c1", 32'(dispense_cmd), 0);
        step();
        check_eq("t1_cmd_c2", 32'(dispense_cmd), 0);
        step();
        check_eq("t1_cmd_c3", 32'(dispense_cmd), 1);
        check_eq("t1_item", 32'(item_select), 3);
        step();
        check_eq("t1_cmd_off", 32'(dispense_cmd), 0);
        dispense_active = 1'b1;
        repeat (10) step();
        dispense_active = 1'b0;
        check_eq("t1_no_early_change", 32'(change_valid), 0);
        step();
        check_eq("t1_change_valid", 32'(change_valid), 1);
        check_eq("t1_change_amt", 32'(change_amount), 25);
        step();
        check_eq("t1_credit_end", 32'(credit), 0);
        check_eq("t1_change_clr", 32'(change_amount), 0);
        check_eq("t1_idle", 32'(busy), 0);

        // 2: credit 50, item 3 @75 -> insufficient, then cancel
        put_coin(8'd25);
        put_coin(8'd25);
        select(4'd3);
        step();
        step();
        check_eq("t2_insufficient", 32'(insufficient), 1);
        check_eq("t2_cmd", 32'(dispense_cmd), 0);
        check_eq("t2_credit", 32'(credit), 50);
        step();
        check_eq("t2_insuf_pulse", 32'(insufficient), 0);
        check_eq("t2_cmd_later", 32'(dispense_cmd), 0);
        do_cancel();
        check_eq("t2_change_valid", 32'(change_valid), 1);
        check_eq("t2_change_amt", 32'(change_amount), 50);
        step();
        check_eq("t2_credit_end", 32'(credit), 0);

        // Disabled item (price 0)
        put_coin(8'd50);
        select(4'd7);
        step();
        step();
        check_eq("dis_insufficient", 32'(insufficient), 1);
        do_cancel();
        step();

        // 3: controller error -> fault, refund 100
        put_coin(8'd50);
        put_coin(8'd50);
        select(4'd2);
        step();
        step();
        check_eq("t3_cmd", 32'(dispense_cmd), 1);
        step();
        error_state = 1'b1;
        dispense_active = 1'b1;
        step();
        error_state = 1'b0;
        dispense_active = 1'b0;
        check_eq("t3_fault", 32'(fault), 1);
        check_eq("t3_change_valid", 32'(change_valid), 1);
        check_eq("t3_change_amt", 32'(change_amount), 100);
        step();
        check_eq("t3_credit_end", 32'(credit), 0);

        // 4: silent controller -> fault after 16 WAIT_ACK cycles
        put_coin(8'd50);
        put_coin(8'd50);
        select(4'd2);
        step();
        step();
        step();
        repeat (15) step();
        check_eq("t4_no_fault_yet", 32'(fault), 0);
        check_eq("t4_busy", 32'(busy), 1);
        step();
        check_eq("t4_fault", 32'(fault), 1);
        check_eq("t4_refund", 32'(change_amount), 100);
        step();
        check_eq("t4_idle", 32'(busy), 0);

        // 5: MAX_CREDIT guard and coin during WAIT_DONE
        repeat (4) put_coin(8'd200);
        put_coin(8'd190);
        check_eq("t5_credit990", 32'(credit), 990);
        put_coin(8'd25);
        check_eq("t5_reject", 32'(coin_reject), 1);
        check_eq("t5_credit_kept", 32'(credit), 990);
        put_coin(8'd10);
        check_eq("t5_max_ok", 32'(coin_reject), 0);
        check_eq("t5_credit1000", 32'(credit), 1000);
        do_cancel();
        check_eq("t5_refund1000", 32'(change_amount), 1000);
        step();
        put_coin(8'd100);
        select(4'd5);
        step();
        step();
        step();
        dispense_active = 1'b1;
        step();
        put_coin(8'd25);
        check_eq("t5_wd_reject", 32'(coin_reject), 1);
        check_eq("t5_wd_credit", 32'(credit), 100);
        dispense_active = 1'b0;
        step();
        check_eq("t5_change", 32'(change_amount), 75);
        step();

        // Idle timeout (40 cycles in this bench) -> full refund
        put_coin(8'd10);
        repeat (39) step();
        check_eq("idle_not_yet", 32'(change_valid), 0);
        step();
        check_eq("idle_refund_valid", 32'(change_valid), 1);
        check_eq("idle_refund_amt", 32'(change_amount), 10);
        step();

        // 6: reset during WAIT_DONE
        put_coin(8'd100);
        select(4'd5);
        step();
        step();
        step();
        dispense_active = 1'b1;
        step();
        check_eq("t6_in_wait", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_credit", 32'(credit), 0);
        check_eq("t6_rst_busy", 32'(busy), 0);
        check_eq("t6_rst_item", 32'(item_select), 0);
        dispense_active = 1'b0;
        step();
        check_eq("t6_rst_change", 32'(change_valid), 0);
        rst_n = 1'b1;
        step();
        check_eq("t6_no_change", 32'(change_valid), 0);

        // Same-cycle coin + selection, exact price -> no change
        coin_valid = 1'b1;
        coin_value = 8'd25;
        select(4'd5);
        coin_valid = 1'b0;
        check_eq("t6_same_credit", 32'(credit), 25);
        step();
        step();
        check_eq("t6_same_cmd", 32'(dispense_cmd), 1);
        step();
        dispense_active = 1'b1;
        step();
        dispense_active = 1'b0;
        step();
        check_eq("t6_exact_no_change", 32'(change_valid), 0);
        check_eq("t6_payout_busy", 32'(busy), 1);
        step();
        check_eq("t6_credit_end", 32'(credit), 0);
        check_eq("t6_idle_end", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
